// File: rtl/fine_capture_encoder.sv
`default_nettype none
// ============================================================================
// Module   : fine_capture_encoder
// Purpose  : Multi-channel TDC fine-time front end. Each channel runs iHit
//            through a tapped delay line (CARRY4 chain, or a shift-register
//            model when DEBUG_CHAIN=1). The taps are registered into a
//            first-column register. On a start strobe and then a stop strobe
//            it snapshots that register and counts the cycles in between.
//            Both snapshots are converted to ones-counts by a two-stage
//            popcount. The result is presented with a valid/ready handshake.
// Ports    : clk            single clock
//            iRst           synchronous active-high reset
//            iHit[c]        hit input feeding channel c's delay line
//            iArm[c]        arm channel c for one measurement (IDLE only)
//            iStartEnable   start-capture strobe per channel
//            iStopEnable    stop-capture strobe per channel
//            iReady[c]      consumer accepts channel c's result
//            oValid[c]      result available
//            oStartCount    start snapshot ones-count, COUNT_W per channel
//            oStopCount     stop snapshot ones-count, COUNT_W per channel
//            oCoarse        cycles from start to stop, COARSE_W per channel
//            oOverflow[c]   coarse counter saturated before stop
//            oBusy[c]       channel is not IDLE
// Revision : 1.0  initial release
// ============================================================================
module fine_capture_encoder #(
  parameter int NUM_TAPS    = 128,
  parameter int NUM_CH      = 2,
  parameter int COARSE_W    = 16,
  parameter int DEBUG_CHAIN = 0,
  localparam int COUNT_W    = $clog2(NUM_TAPS + 1)
) (
  input  logic                         clk,
  input  logic                         iRst,
  input  logic [NUM_CH-1:0]            iHit,
  input  logic [NUM_CH-1:0]            iArm,
  input  logic [NUM_CH-1:0]            iStartEnable,
  input  logic [NUM_CH-1:0]            iStopEnable,
  input  logic [NUM_CH-1:0]            iReady,
  output logic [NUM_CH-1:0]            oValid,
  output logic [NUM_CH*COUNT_W-1:0]    oStartCount,
  output logic [NUM_CH*COUNT_W-1:0]    oStopCount,
  output logic [NUM_CH*COARSE_W-1:0]   oCoarse,
  output logic [NUM_CH-1:0]            oOverflow,
  output logic [NUM_CH-1:0]            oBusy
);

  localparam logic [2:0] c_IDLE       = 3'd0;
  localparam logic [2:0] c_WAIT_START = 3'd1;
  localparam logic [2:0] c_RUN        = 3'd2;
  localparam logic [2:0] c_ENC1       = 3'd3;
  localparam logic [2:0] c_ENC2       = 3'd4;
  localparam logic [2:0] c_VALID      = 3'd5;

  // One CARRY4 cell and one popcount group cover four taps each.
  localparam int c_GROUPS = NUM_TAPS / 4;

  function automatic logic [2:0] pop4(input logic [3:0] v);
    pop4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch

    logic [NUM_TAPS-1:0] w_tap;
    (* DONT_TOUCH = "TRUE" *) logic [NUM_TAPS-1:0] r_first;

    // ------------------------------------------------------------------
    // Delay line
    // ------------------------------------------------------------------
    if (DEBUG_CHAIN == 0) begin : g_carryChain
      for (genvar j = 0; j < c_GROUPS; j++) begin : g_cell
        logic [3:0] w_co;
        logic       w_ci;
        logic       w_cyInit;

        // The hit enters through CYINIT of the first cell only; later cells
        // are chained purely through the dedicated carry path.
        if (j == 0) begin : g_head
          assign w_ci     = 1'b0;
          assign w_cyInit = iHit[c];
        end else begin : g_link
          assign w_ci     = g_cell[j-1].w_co[3];
          assign w_cyInit = 1'b0;
        end

        (* DONT_TOUCH = "TRUE" *)
        CARRY4 u_carry4 (
          .CO     (w_co),
          .O      (),
          .CI     (w_ci),
          .CYINIT (w_cyInit),
          .DI     (4'b0000),
          .S      (4'b1111)
        );

        assign w_tap[4*j +: 4] = w_co;
      end
    end else begin : g_shiftModel
      logic [NUM_TAPS-1:0] r_tap;

      always_ff @(posedge clk) begin
        if (iRst) begin
          r_tap <= '0;
        end else begin
          r_tap <= {r_tap[NUM_TAPS-2:0], iHit[c]};
        end
      end

      assign w_tap = r_tap;
    end

    // First-column capture of every tap, unconditionally each cycle.
    always_ff @(posedge clk) begin
      if (iRst) begin
        r_first <= '0;
      end else begin
        r_first <= w_tap;
      end
    end

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    logic [2:0]            r_state;
    logic [2:0]            w_nextState;
    logic [COARSE_W-1:0]   r_coarseCnt;
    logic [COARSE_W-1:0]   w_coarseInc;
    logic [COARSE_W-1:0]   r_coarseOut;
    logic                  w_atLimit;
    logic                  r_valid;
    logic                  r_overflow;
    logic                  w_busy;
    logic                  w_capStart;
    logic                  w_capStop;
    logic                  w_saturate;
    logic                  w_loadCounts;
    logic                  w_setValid;
    logic                  w_accept;

    // The counter reads k-1 on the k-th cycle after start, so the value
    // latched at stop (and tested for saturation) is the incremented one.
    assign w_coarseInc = r_coarseCnt + COARSE_W'(1);
    assign w_atLimit   = (w_coarseInc == {COARSE_W{1'b1}});

    always_ff @(posedge clk) begin
      if (iRst) begin
        r_state <= c_IDLE;
      end else begin
        r_state <= w_nextState;
      end
    end

    always_comb begin
      w_nextState = r_state;
      case (r_state)
        c_IDLE:       if (iArm[c])                     w_nextState = c_WAIT_START;
        c_WAIT_START: if (iStartEnable[c])             w_nextState = c_RUN;
        c_RUN:        if (iStopEnable[c] || w_atLimit) w_nextState = c_ENC1;
        c_ENC1:                                        w_nextState = c_ENC2;
        c_ENC2:                                        w_nextState = c_VALID;
        c_VALID:      if (r_valid && iReady[c])        w_nextState = c_IDLE;
        default:                                       w_nextState = c_IDLE;
      endcase
    end

    always_comb begin
      w_busy       = (r_state != c_IDLE);
      w_capStart   = 1'b0;
      w_capStop    = 1'b0;
      w_saturate   = 1'b0;
      w_loadCounts = 1'b0;
      w_setValid   = 1'b0;
      w_accept     = 1'b0;
      case (r_state)
        c_WAIT_START: w_capStart = iStartEnable[c];
        c_RUN: begin
          // A stop on the saturating cycle still wins over overflow.
          w_capStop  = iStopEnable[c];
          w_saturate = !iStopEnable[c] && w_atLimit;
        end
        c_ENC2:       w_loadCounts = 1'b1;
        c_VALID: begin
          // oValid is raised on the first VALID cycle, giving three cycles
          // from the stop edge to oValid.
          w_setValid = !r_valid;
          w_accept   = r_valid && iReady[c];
        end
        default: ;
      endcase
    end

    // ------------------------------------------------------------------
    // Snapshots and two-stage popcount
    // ------------------------------------------------------------------
    logic [NUM_TAPS-1:0]    r_startSnap;
    logic [NUM_TAPS-1:0]    r_stopSnap;
    logic [c_GROUPS*3-1:0]  w_grpStart;
    logic [c_GROUPS*3-1:0]  w_grpStop;
    logic [c_GROUPS*3-1:0]  r_grpStart;
    logic [c_GROUPS*3-1:0]  r_grpStop;
    logic [COUNT_W-1:0]     w_sumStart;
    logic [COUNT_W-1:0]     w_sumStop;
    logic [COUNT_W-1:0]     r_startCnt;
    logic [COUNT_W-1:0]     r_stopCnt;

    // Stage 1: 4-tap group counts, registered every cycle. Stage 2: sum of
    // groups, registered when leaving ENC2. Neither stage holds state that
    // depends on a previous cycle, so idle cycles between stages are harmless.
    always_comb begin
      w_grpStart = '0;
      w_grpStop  = '0;
      for (int g = 0; g < c_GROUPS; g++) begin
        w_grpStart[3*g +: 3] = pop4(r_startSnap[4*g +: 4]);
        w_grpStop[3*g +: 3]  = pop4(r_stopSnap[4*g +: 4]);
      end
    end

    always_comb begin
      w_sumStart = '0;
      w_sumStop  = '0;
      for (int g = 0; g < c_GROUPS; g++) begin
        w_sumStart = w_sumStart + {{(COUNT_W-3){1'b0}}, r_grpStart[3*g +: 3]};
        w_sumStop  = w_sumStop  + {{(COUNT_W-3){1'b0}}, r_grpStop[3*g +: 3]};
      end
    end

    always_ff @(posedge clk) begin
      if (iRst) begin
        r_startSnap <= '0;
        r_stopSnap  <= '0;
        r_grpStart  <= '0;
        r_grpStop   <= '0;
        r_coarseCnt <= '0;
        r_coarseOut <= '0;
        r_startCnt  <= '0;
        r_stopCnt   <= '0;
        r_valid     <= 1'b0;
        r_overflow  <= 1'b0;
      end else begin
        r_grpStart <= w_grpStart;
        r_grpStop  <= w_grpStop;

        if (w_capStart) begin
          r_startSnap <= r_first;
          r_coarseCnt <= '0;
        end else if (r_state == c_RUN) begin
          r_coarseCnt <= w_coarseInc;
        end

        if (w_capStop) begin
          r_stopSnap  <= r_first;
          r_coarseOut <= w_coarseInc;
          r_overflow  <= 1'b0;
        end else if (w_saturate) begin
          r_stopSnap  <= '0;
          r_coarseOut <= '1;
          r_overflow  <= 1'b1;
        end

        if (w_loadCounts) begin
          r_startCnt <= w_sumStart;
          r_stopCnt  <= w_sumStop;
        end

        // Counts and coarse value stay put after the handshake; only the
        // valid and overflow flags drop.
        if (w_setValid) begin
          r_valid <= 1'b1;
        end else if (w_accept) begin
          r_valid    <= 1'b0;
          r_overflow <= 1'b0;
        end
      end
    end

    assign oValid[c]                       = r_valid;
    assign oOverflow[c]                    = r_overflow;
    assign oBusy[c]                        = w_busy;
    assign oStartCount[c*COUNT_W +: COUNT_W] = r_startCnt;
    assign oStopCount[c*COUNT_W +: COUNT_W]  = r_stopCnt;
    assign oCoarse[c*COARSE_W +: COARSE_W]   = r_coarseOut;
  end

endmodule

`ifndef SYNTHESIS
// ============================================================================
// Module   : CARRY4
// Purpose  : Behavioural stand-in for the vendor 4-bit carry primitive, used
//            when the vendor library is not present. Synthesis uses the real
//            primitive.
// Ports    : CI, CYINIT carry inputs; DI, S data/select; CO carries; O sums
// Revision : 1.0  initial release
// ============================================================================
module CARRY4 (
  output logic [3:0] CO,
  output logic [3:0] O,
  input  logic       CI,
  input  logic       CYINIT,
  input  logic [3:0] DI,
  input  logic [3:0] S
);

  always_comb begin
    logic carry;
    carry = CI | CYINIT;
    CO    = '0;
    O     = '0;
    for (int i = 0; i < 4; i++) begin
      O[i]  = S[i] ^ carry;
      CO[i] = S[i] ? carry : DI[i];
      carry = CO[i];
    end
  end

endmodule
`endif

`default_nettype wire
